mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-into-one request arbiter that lets the CPU core's instruction-fetch port and data-access port share a single SRAM-like memory port. It sits between the pipeline (fetch stage = inst requester, execute/memory stages = data requester) and the downstream memory or bus bridge. It allows one outstanding transaction at a time, routes `addr_ok`/`data_ok` back to the owning requester only, and prioritises data over instruction by default.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; write strobe width is `DATA_W/8`
- `clk`  in  1  system clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_wstrb[3:0]`, `inst_addr[ADDR_W]`, `inst_wdata[DATA_W]`  in  instruction-port request fields; held stable while `inst_req` is high and `inst_addr_ok` is low
- `inst_addr_ok`  out  1  request accepted this cycle
- `inst_data_ok`  out  1  response valid this cycle
- `inst_rdata`  out  DATA_W  read data, valid with `inst_data_ok`
- `data_req`, `data_wr`, `data_size[1:0]`, `data_wstrb[3:0]`, `data_addr`, `data_wdata`  in  data-port request fields, same rules as the instruction port
- `data_addr_ok`, `data_data_ok`  out  1 each; `data_rdata`  out  DATA_W
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_wstrb[3:0]`, `mem_addr`, `mem_wdata`  out  downstream request
- `mem_addr_ok`, `mem_data_ok`  in  1 each; `mem_rdata`  in  DATA_W

## Operation
- FSM states: IDLE, ADDR (request issued and stalled), RESP (waiting for `mem_data_ok`); `owner` register is 1 bit (INST/DATA).
- IDLE: if any request is pending, select the winner combinationally and drive `mem_*` from the winner's fields in the same cycle.
  - If `mem_addr_ok` is high: assert the winner's `addr_ok`, latch `owner`, and go to RESP.
  - If `mem_addr_ok` is low: latch `owner` and go to ADDR.
- ADDR: drive `mem_*` from the latched owner's fields only; the grant is locked and is not re-arbitrated. When `mem_addr_ok` is high, assert the owner's `addr_ok` and go to RESP.
- RESP: `mem_req` is 0. When `mem_data_ok` is high, pass it to the owner's `data_ok` and go to IDLE.
- `mem_rdata` drives both `inst_rdata` and `data_rdata` unregistered. Only the owner's `data_ok` qualifies the data.
- The non-owner's `addr_ok` and `data_ok` are always 0.
- Default arbitration: `data_req` wins over `inst_req`.
- `mem_data_ok` in IDLE or ADDR is a protocol violation. It is ignored and no `data_ok` is produced.
- Write transactions also wait for `mem_data_ok` (write acknowledge) before returning to IDLE.

## Timing
- Reset values: FSM = IDLE, `owner` = INST, round-robin pointer = INST. All `*_addr_ok`, `*_data_ok` and `mem_req` outputs read 0 while in reset.
- Request path is combinational: the earliest accept is in the same cycle `req` rises, if the memory returns `mem_addr_ok` = 1 in that cycle.
- A response may arrive at the earliest one cycle after address acceptance.
- After `data_ok`, the next request issues in the following cycle. The minimum transaction length is 2 cycles, so peak throughput is one transaction per 2 cycles.
- Simultaneous requests in IDLE: exactly one is granted. The loser keeps `req` high and is served after the winner's `data_ok`.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and any pending response is dropped. The downstream port is reset alongside the arbiter.

## Configuration
- `MEM_ARB_RR_EN` not defined: fixed priority, data over instruction.
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - Applies only when both requesters are pending in IDLE.
  - The requester not granted most recently wins.
  - The pointer updates when a transaction's address is accepted.
  - A lone requester is always granted.

## Structure
- Package `mem_arb_pkg`:
  - FSM state encoding (IDLE/ADDR/RESP)
  - owner encoding (OWN_INST = 0, OWN_DATA = 1)
  - size constants (SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2)
- Sub-module `mem_arb_grant`: combinational winner select from `{inst_req, data_req}` plus the round-robin pointer. Owns the pointer register when `MEM_ARB_RR_EN` is defined.
- Request muxing and the FSM stay in `mem_req_arbiter`.

## Test plan
- **Lone inst read.** `inst_req=1, inst_addr=0x1C000000`, memory gives `addr_ok` at once and `data_ok` with `rdata=0x02800C0C` one cycle later.
  - Response: `inst_addr_ok` in cycle 0, `inst_data_ok` with `inst_rdata=0x02800C0C` in cycle 1, `data_*_ok` stay 0.
- **Collision, default build.** `inst_req` and `data_req` (write `0x8000_0010`, `wstrb=0xF`) rise together.
  - Response: data is issued first with `mem_wr=1`; inst is issued in the cycle after `data_data_ok`.
- **Address stall.** `mem_addr_ok` held low for 3 cycles while `data_req` wins, and `inst_req` rises in cycle 1.
  - Response: `mem_addr` stays `data_addr` for all 4 cycles (grant locked) and `inst_addr_ok` stays 0.
- **Round-robin, `MEM_ARB_RR_EN` defined.** Both requesters continuously requesting.
  - Response: grants alternate DATA, INST, DATA, INST…, and neither side is starved.
- **Reset in RESP.** Drop `resetn` after `data_addr_ok`, before `mem_data_ok`.
  - Response: all ok outputs are 0 immediately; after release a new `inst_req` issues from IDLE.
- **Stray response.** `mem_data_ok=1` in IDLE.
  - Response: no `*_data_ok` asserted and the FSM stays in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-into-one memory request arbiter.
// Consumers import mem_arb_pkg::*; round-robin build is selected by MEM_ARB_RR_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select between the instruction and data requesters.
// With MEM_ARB_RR_EN defined it owns the round-robin pointer; otherwise data has fixed priority.
module mem_arb_grant
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic clk,
   input  logic resetn,
   input  logic accept_i,
   input  logic accept_owner_i,
`endif
   input  logic inst_req_i,
   input  logic data_req_i,
   output logic winner_o
);

`ifdef MEM_ARB_RR_EN
   // last_q holds the most recently granted requester; the other one wins a tie.
   owner_e last_q;
   owner_e last_d;

   always_comb begin
      last_d = last_q;
      if (accept_i) begin
         last_d = owner_e'(accept_owner_i);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= OWN_INST;
      end else begin
         last_q <= last_d;
      end
   end

   always_comb begin
      winner_o = OWN_INST;
      if (inst_req_i && data_req_i) begin
         winner_o = (last_q == OWN_INST) ? OWN_DATA : OWN_INST;
      end else if (data_req_i) begin
         winner_o = OWN_DATA;
      end
   end
`else
   logic unused_inst_req;
   assign unused_inst_req = inst_req_i;

   always_comb begin
      winner_o = data_req_i ? OWN_DATA : OWN_INST;
   end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-instruction priority.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [DATA_W/8-1:0] inst_wstrb,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state_o,
   output logic              dbg_owner_o
);

   arb_state_e state_q, state_d;
   owner_e     owner_q, owner_d;
   owner_e     sel_owner;
   logic       grant_winner;
   logic       req_raw;
   logic       accept;
   logic       resp;

   mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
      .clk            (clk),
      .resetn         (resetn),
      .accept_i       (accept),
      .accept_owner_i (sel_owner),
`endif
      .inst_req_i     (inst_req),
      .data_req_i     (data_req),
      .winner_o       (grant_winner)
   );

   // Only IDLE arbitrates; ADDR and RESP stay locked on the latched owner.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      req_raw   = 1'b0;
      sel_owner = (state_q == ST_IDLE) ? owner_e'(grant_winner) : owner_q;
      case (state_q)
         ST_IDLE: begin
            if (inst_req || data_req) begin
               req_raw = 1'b1;
               owner_d = owner_e'(grant_winner);
               state_d = mem_addr_ok ? ST_RESP : ST_ADDR;
            end
         end
         ST_ADDR: begin
            req_raw = 1'b1;
            if (mem_addr_ok) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_data_ok) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Gating on resetn keeps every handshake output quiet while reset is held.
   assign mem_req = req_raw & resetn;
   assign accept  = mem_req & mem_addr_ok;
   assign resp    = resetn & (state_q == ST_RESP) & mem_data_ok;

   assign inst_addr_ok = accept & (sel_owner == OWN_INST);
   assign data_addr_ok = accept & (sel_owner == OWN_DATA);
   assign inst_data_ok = resp & (owner_q == OWN_INST);
   assign data_data_ok = resp & (owner_q == OWN_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign mem_wr    = (sel_owner == OWN_DATA) ? data_wr    : inst_wr;
   assign mem_size  = (sel_owner == OWN_DATA) ? data_size  : inst_size;
   assign mem_wstrb = (sel_owner == OWN_DATA) ? data_wstrb : inst_wstrb;
   assign mem_addr  = (sel_owner == OWN_DATA) ? data_addr  : inst_addr;
   assign mem_wdata = (sel_owner == OWN_DATA) ? data_wdata : inst_wdata;

   assign dbg_state_o = state_q;
   assign dbg_owner_o = owner_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter; follows MEM_ARB_RR_EN like the design.
// Responses are checked by a monitor against a queue of {is_data, rdata} entries.
module tb_mem_req_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          resetn;
   logic          inst_req, inst_wr, data_req, data_wr;
   logic [1:0]    inst_size, data_size, mem_size;
   logic [3:0]    inst_wstrb, data_wstrb, mem_wstrb;
   logic [AW-1:0] inst_addr, data_addr, mem_addr;
   logic [DW-1:0] inst_wdata, data_wdata, mem_wdata;
   logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [DW-1:0] inst_rdata, data_rdata, mem_rdata;
   logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [1:0]    dbg_state;
   logic          dbg_owner;

   int checks = 0;
   int errors = 0;
   logic [DW:0] exp_q[$];

   always #5 clk = ~clk;

   mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .dbg_state_o(dbg_state), .dbg_owner_o(dbg_owner)
   );

   // Response monitor: every data_ok pops one expected {is_data, rdata}.
   always @(negedge clk) begin
      if (resetn && (inst_data_ok || data_data_ok)) begin
         checks++;
         if (inst_data_ok && data_data_ok) begin
            errors++;
            $display("FAIL resp_both: inst_data_ok=%b data_data_ok=%b, required one-hot", inst_data_ok, data_data_ok);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: data_ok with rdata=%h, required no response", mem_rdata);
         end else begin
            logic [DW:0] exp_e, got_e;
            exp_e = exp_q.pop_front();
            got_e = {data_data_ok, data_data_ok ? data_rdata : inst_rdata};
            if (got_e !== exp_e) begin
               errors++;
               $display("FAIL resp_data: got port=%b rdata=%h, required port=%b rdata=%h",
                        got_e[DW], got_e[DW-1:0], exp_e[DW], exp_e[DW-1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'h0; inst_addr = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'h0; data_addr = '0; data_wdata = '0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 0;
      inst_req = 1;
      mem_addr_ok = 1;
      at_neg();
      checks++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_outputs: oks=%b mem_req=%b state=%0d, required 0/0/IDLE",
                  {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, mem_req, dbg_state);
      end
      tick();
      idle_inputs();
      resetn = 1;
      tick();
   endtask

   task automatic test_lone_inst_read();
      inst_req = 1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
      exp_q.push_back({1'b0, 32'h0280_0C0C});
      at_neg();
      checks++;
      if (!(inst_addr_ok === 1'b1 && data_addr_ok === 1'b0 && mem_req === 1'b1 && mem_addr === 32'h1C00_0000 && mem_wr === 1'b0)) begin
         errors++;
         $display("FAIL lone_accept: inst_addr_ok=%b data_addr_ok=%b mem_req=%b mem_addr=%h, required 1/0/1/1c000000",
                  inst_addr_ok, data_addr_ok, mem_req, mem_addr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
      at_neg();
      checks++;
      if (!(inst_data_ok === 1'b1 && data_data_ok === 1'b0 && mem_req === 1'b0)) begin
         errors++;
         $display("FAIL lone_resp: inst_data_ok=%b data_data_ok=%b mem_req=%b, required 1/0/0",
                  inst_data_ok, data_data_ok, mem_req);
      end
      tick();
      mem_data_ok = 0;
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL lone_idle: state=%0d, required %0d", dbg_state, ST_IDLE);
      end
   endtask

   task automatic test_collision();
      inst_req = 1; inst_addr = 32'h1C00_0004;
      data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
      mem_addr_ok = 1;
      exp_q.push_back({1'b1, 32'h0000_0000});
      at_neg();
      checks++;
      if (!(data_addr_ok === 1'b1 && inst_addr_ok === 1'b0 && mem_wr === 1'b1 && mem_addr === 32'h8000_0010 &&
            mem_wstrb === 4'hF && mem_wdata === 32'hCAFE_F00D)) begin
         errors++;
         $display("FAIL coll_data_first: data_ok=%b inst_ok=%b wr=%b addr=%h wstrb=%h wdata=%h, required 1/0/1/80000010/f/cafef00d",
                  data_addr_ok, inst_addr_ok, mem_wr, mem_addr, mem_wstrb, mem_wdata);
      end
      tick();
      data_req = 0; data_wr = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0;
      at_neg();
      checks++;
      if (!(mem_req === 1'b0 && inst_addr_ok === 1'b0)) begin
         errors++;
         $display("FAIL coll_wait: mem_req=%b inst_addr_ok=%b during write ack, required 0/0", mem_req, inst_addr_ok);
      end
      tick();
      mem_data_ok = 0;
      exp_q.push_back({1'b0, 32'h1234_5678});
      at_neg();
      checks++;
      if (!(inst_addr_ok === 1'b1 && mem_addr === 32'h1C00_0004 && mem_wr === 1'b0)) begin
         errors++;
         $display("FAIL coll_inst_next: inst_addr_ok=%b mem_addr=%h mem_wr=%b, required 1/1c000004/0",
                  inst_addr_ok, mem_addr, mem_wr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_addr_stall();
      data_req = 1; data_addr = 32'h8000_0100; mem_addr_ok = 0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            inst_req = 1; inst_addr = 32'h1C00_0008;
         end
         if (c == 3) begin
            mem_addr_ok = 1;
            exp_q.push_back({1'b1, 32'hDEAD_0001});
         end
         at_neg();
         checks++;
         if (!(mem_req === 1'b1 && mem_addr === 32'h8000_0100 && inst_addr_ok === 1'b0 && data_addr_ok === (c == 3))) begin
            errors++;
            $display("FAIL stall_c%0d: mem_addr=%h inst_addr_ok=%b data_addr_ok=%b, required 80000100/0/%0d",
                     c, mem_addr, inst_addr_ok, data_addr_ok, (c == 3));
         end
         tick();
      end
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_0001;
      tick();
      mem_data_ok = 0; mem_addr_ok = 1;
      exp_q.push_back({1'b0, 32'hDEAD_0002});
      at_neg();
      checks++;
      if (!(inst_addr_ok === 1'b1 && mem_addr === 32'h1C00_0008)) begin
         errors++;
         $display("FAIL stall_inst_after: inst_addr_ok=%b mem_addr=%h, required 1/1c000008", inst_addr_ok, mem_addr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_0002;
      tick();
      mem_data_ok = 0;
   endtask

   // Both sides request continuously; the last grant before this test was INST.
   task automatic test_back_to_back();
      logic exp_data;
      logic [DW-1:0] rd;
      inst_req = 1; inst_addr = 32'h1C00_0100;
      data_req = 1; data_addr = 32'h8000_0200;
      exp_data = 1'b1;
      for (int t = 0; t < 6; t++) begin
         rd = $urandom_range(0, 32'h7FFF_FFFF);
         mem_addr_ok = 1; mem_data_ok = 0;
         exp_q.push_back({exp_data, rd});
         at_neg();
         checks++;
         if (!(data_addr_ok === exp_data && inst_addr_ok === !exp_data &&
               mem_addr === (exp_data ? 32'h8000_0200 : 32'h1C00_0100))) begin
            errors++;
            $display("FAIL b2b_grant%0d: data_addr_ok=%b inst_addr_ok=%b mem_addr=%h, required data=%b",
                     t, data_addr_ok, inst_addr_ok, mem_addr, exp_data);
         end
         tick();
         mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rd;
         tick();
`ifdef MEM_ARB_RR_EN
         exp_data = !exp_data;
`endif
      end
      inst_req = 0; data_req = 0; mem_data_ok = 0;
      tick();
   endtask

   task automatic test_reset_in_resp();
      data_req = 1; data_addr = 32'h8000_0300; mem_addr_ok = 1;
      at_neg();
      checks++;
      if (data_addr_ok !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_accept: data_addr_ok=%b, required 1", data_addr_ok);
      end
      tick();
      data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0200;
      resetn = 0;
      #1;
      checks++;
      if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0 || dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL rst_in_resp: mem_req=%b oks=%b state=%0d, required 0/0/IDLE", mem_req,
                  {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, dbg_state);
      end
      tick();
      resetn = 1;
      exp_q.push_back({1'b0, 32'h5555_AAAA});
      at_neg();
      checks++;
      if (!(inst_addr_ok === 1'b1 && mem_addr === 32'h1C00_0200)) begin
         errors++;
         $display("FAIL rst_new_inst: inst_addr_ok=%b mem_addr=%h, required 1/1c000200", inst_addr_ok, mem_addr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_stray_response();
      mem_data_ok = 1; mem_rdata = 32'hBAD0_BAD0;
      for (int c = 0; c < 2; c++) begin
         at_neg();
         checks++;
         if (!(inst_data_ok === 1'b0 && data_data_ok === 1'b0 && dbg_state === ST_IDLE)) begin
            errors++;
            $display("FAIL stray_c%0d: inst_data_ok=%b data_data_ok=%b state=%0d, required 0/0/IDLE",
                     c, inst_data_ok, data_data_ok, dbg_state);
         end
         tick();
      end
      mem_data_ok = 0;
   endtask

   initial begin
      idle_inputs();
      resetn = 0;
      tick();
      test_reset();
      test_lone_inst_read();
      test_collision();
      test_addr_stall();
      test_back_to_back();
      test_reset_in_resp();
      test_stray_response();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
